// File: rtl/traffic_request_encoder.sv
// Debounces three roadside detectors into sticky requests and hands one request at a time
// to the traffic-light controller, holding it until the light output shows it was served.
module traffic_request_encoder #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       det_main,
    input  logic       det_side,
    input  logic       ped_btn,
    input  logic [3:0] lights_i,
    output logic [1:0] req_code,
    output logic       req_en,
    output logic [2:0] pending,
    output logic       stuck
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_MAIN = 2'b01;
    localparam logic [1:0] CODE_SIDE = 2'b10;
    localparam logic [1:0] CODE_PED  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_WAIT,
        ST_CLEAR
    } state_t;

    logic [2:0] det_vec;
    logic [2:0] rise;

    assign det_vec = {ped_btn, det_side, det_main};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_det
            logic             sync1_q;
            logic             sync2_q;
            logic             level_q;
            logic             level_prev_q;
            logic [CNT_W-1:0] cnt_q;

            // Level flips once the synchronised value has disagreed with it past the debounce window.
            always_ff @(posedge clk or posedge res_n) begin
                if (res_n) begin
                    sync1_q      <= 1'b0;
                    sync2_q      <= 1'b0;
                    level_q      <= 1'b0;
                    level_prev_q <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    sync1_q      <= det_vec[gi];
                    sync2_q      <= sync1_q;
                    level_prev_q <= level_q;
                    if (sync2_q == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        level_q <= ~level_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end

            assign rise[gi] = level_q & ~level_prev_q;
        end
    endgenerate

    state_t           state_q;
    logic [1:0]       sel_q;
    logic [1:0]       sel_d;
    logic [2:0]       pending_q;
    logic [2:0]       pending_d;
    logic [2:0]       clr_mask;
    logic [CNT_W-1:0] tcnt_q;
    logic             last_side_q;
    logic             served;
    logic [1:0]       req_code_q;
    logic             req_en_q;
    logic             stuck_q;

    // Pedestrian wins outright; a main/side tie goes to whichever was not served last.
    always_comb begin
        sel_d = CODE_NONE;
        if (pending_q[2]) begin
            sel_d = CODE_PED;
        end else if (pending_q[1] && pending_q[0]) begin
            sel_d = last_side_q ? CODE_MAIN : CODE_SIDE;
        end else if (pending_q[1]) begin
            sel_d = CODE_SIDE;
        end else if (pending_q[0]) begin
            sel_d = CODE_MAIN;
        end
    end

    always_comb begin
        served   = 1'b0;
        clr_mask = 3'b000;
        case (sel_q)
            CODE_MAIN: served = (lights_i[1:0] == 2'b10);
            CODE_SIDE: served = (lights_i[3:2] == 2'b10);
            CODE_PED:  served = (lights_i == 4'b0000);
            default:   served = 1'b0;
        endcase
        if (state_q == ST_CLEAR) begin
            case (sel_q)
                CODE_MAIN: clr_mask = 3'b001;
                CODE_SIDE: clr_mask = 3'b010;
                CODE_PED:  clr_mask = 3'b100;
                default:   clr_mask = 3'b000;
            endcase
        end
        // A new event in the same cycle as the clear keeps the bit set.
        pending_d = (pending_q & ~clr_mask) | rise;
    end

    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= CODE_NONE;
            pending_q   <= 3'b000;
            tcnt_q      <= '0;
            last_side_q <= 1'b0;
            req_code_q  <= CODE_NONE;
            req_en_q    <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                ST_IDLE: begin
                    req_code_q <= CODE_NONE;
                    req_en_q   <= 1'b0;
                    if (pending_q != 3'b000) begin
                        sel_q   <= sel_d;
                        state_q <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    req_code_q <= sel_q;
                    req_en_q   <= 1'b1;
                    tcnt_q     <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (served) begin
                        state_q <= ST_CLEAR;
                    end else if (tcnt_q == TO_LAST) begin
                        stuck_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + CNT_W'(1);
                    end
                end
                ST_CLEAR: begin
                    req_code_q <= CODE_NONE;
                    req_en_q   <= 1'b0;
                    stuck_q    <= 1'b0;
                    if (sel_q == CODE_MAIN) begin
                        last_side_q <= 1'b0;
                    end else if (sel_q == CODE_SIDE) begin
                        last_side_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_code = req_code_q;
    assign req_en   = req_en_q;
    assign pending  = pending_q;
    assign stuck    = stuck_q;

endmodule

// File: tb/tb_traffic_request_encoder.sv
// Directed bench: stimulus pushes expected request codes, a monitor pops and compares
// them whenever req_en rises; timing and boundary checks are made inline.
module tb_traffic_request_encoder;

    logic       clk = 1'b0;
    logic       res_n;
    logic       det_main;
    logic       det_side;
    logic       ped_btn;
    logic [3:0] lights_i;
    logic [1:0] req_code;
    logic       req_en;
    logic [2:0] pending;
    logic       stuck;

    traffic_request_encoder #(
        .DEBOUNCE(4),
        .TIMEOUT (64),
        .CNT_W   (8)
    ) dut (
        .clk     (clk),
        .res_n   (res_n),
        .det_main(det_main),
        .det_side(det_side),
        .ped_btn (ped_btn),
        .lights_i(lights_i),
        .req_code(req_code),
        .req_en  (req_en),
        .pending (pending),
        .stuck   (stuck)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] exp_q[$];
    logic       prev_en  = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    // Monitor: every new presentation of a request is one transaction.
    always @(negedge clk) begin
        if (req_en && !prev_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_request: got code %0d, required no request", req_code);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                $display("txn t=%0t: presented code %0d, expected %0d", $time, req_code, e);
                check("req_code_txn", int'(req_code), int'(e));
            end
        end
        prev_en <= req_en;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_en(input logic val, input string name);
        int k;
        k = 0;
        while (req_en !== val && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(req_en), int'(val));
    endtask

    task automatic pulse(input logic m, input logic s, input logic p, input int n);
        det_main = m;
        det_side = s;
        ped_btn  = p;
        tick(n);
        det_main = 1'b0;
        det_side = 1'b0;
        ped_btn  = 1'b0;
    endtask

    task automatic serve(input logic [3:0] lt, input string name);
        wait_en(1'b1, {name, "_rise"});
        lights_i = lt;
        wait_en(1'b0, {name, "_fall"});
        lights_i = 4'b0101;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        res_n    = 1'b1;
        det_main = 1'b1;
        det_side = 1'b0;
        ped_btn  = 1'b0;
        lights_i = 4'b0000;
        tick(2);
        check("rst_req_en", int'(req_en), 0);
        check("rst_req_code", int'(req_code), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_stuck", int'(stuck), 0);

        // Main detector high from edge 0: pending at edge 7, request at edge 9, served at 12.
        exp_q.push_back(2'b01);
        res_n = 1'b0;
        tick(7);
        check("t1_pend_e6", int'(pending), 0);
        tick(1);
        check("t1_pend_e7", int'(pending), 1);
        tick(1);
        check("t1_en_e8", int'(req_en), 0);
        tick(1);
        check("t1_en_e9", int'(req_en), 1);
        check("t1_code_e9", int'(req_code), 1);
        tick(2);
        lights_i = 4'b0010;
        tick(1);
        check("t1_en_e12", int'(req_en), 1);
        tick(1);
        check("t1_en_e13", int'(req_en), 0);
        check("t1_code_e13", int'(req_code), 0);
        check("t1_pend_e13", int'(pending), 0);
        det_main = 1'b0;
        lights_i = 4'b0101;
        tick(12);

        // Three-cycle glitch is filtered.
        pulse(1'b1, 1'b0, 1'b0, 3);
        tick(15);
        check("t4_glitch_pend", int'(pending), 0);
        check("t4_glitch_en", int'(req_en), 0);

        // Fairness: last served was main, so side goes first, twice in a row.
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(2'b10);
            exp_q.push_back(2'b01);
            pulse(1'b1, 1'b1, 1'b0, 6);
            serve(4'b1000, "t3_side");
            check("t3_pend_after_side", int'(pending), 1);
            serve(4'b0010, "t3_main");
            check("t3_pend_after_main", int'(pending), 0);
            tick(10);
        end

        // Pedestrian beats side; side follows after the two-cycle gap.
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
        pulse(1'b0, 1'b1, 1'b1, 6);
        serve(4'b0000, "t2_ped");
        check("t2_pend_after_ped", int'(pending), 2);
        tick(1);
        check("t2_gap_en", int'(req_en), 0);
        tick(1);
        check("t2_side_en", int'(req_en), 1);
        check("t2_side_code", int'(req_code), 2);
        serve(4'b1000, "t2_side");
        check("t2_pend_end", int'(pending), 0);
        tick(10);

        // Timeout: stuck rises exactly TIMEOUT cycles after entering WAIT.
        exp_q.push_back(2'b01);
        pulse(1'b1, 1'b0, 1'b0, 6);
        lights_i = 4'b0001;
        wait_en(1'b1, "t5_rise");
        tick(63);
        check("t5_stuck_early", int'(stuck), 0);
        tick(1);
        check("t5_stuck_set", int'(stuck), 1);
        tick(5);
        check("t5_stuck_hold", int'(stuck), 1);
        check("t5_en_hold", int'(req_en), 1);
        check("t5_code_hold", int'(req_code), 1);
        lights_i = 4'b0010;
        wait_en(1'b0, "t5_fall");
        check("t5_stuck_clr", int'(stuck), 0);
        lights_i = 4'b0101;
        tick(10);

        // Asynchronous reset in the middle of WAIT.
        exp_q.push_back(2'b01);
        pulse(1'b1, 1'b0, 1'b0, 6);
        wait_en(1'b1, "t6_rise");
        tick(3);
        check("t6_pend_pre", int'(pending), 1);
        #2;
        res_n = 1'b1;
        #1;
        check("t6_async_en", int'(req_en), 0);
        check("t6_async_code", int'(req_code), 0);
        check("t6_async_pend", int'(pending), 0);
        check("t6_async_stuck", int'(stuck), 0);
        @(negedge clk);
        res_n = 1'b0;
        tick(20);
        check("t6_post_en", int'(req_en), 0);
        check("t6_post_pend", int'(pending), 0);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
